// File: rtl/snake_ctrl.sv
// -----------------------------------------------------------------------------
// snake_ctrl
//
// Drives a four-digit, multiplexed seven-segment "snake" animation. A frame
// address steps through FRAMES entries of four external per-digit ROMs at a
// rate of one step every DIV_TICK clocks while running. A free-running scan
// divider rotates the active digit every DIV_SCAN clocks.
//
// Optional feature (compile-time macro SNAKE_REVERSE_EN):
//   adds input 'dir'. When dir=1 the address decrements and wraps 0 -> FRAMES-1.
//   Without the macro the port is absent and the address always increments.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous reset, active-high
//   start        pulse: IDLE -> RUN
//   pause        pulse: toggles RUN <-> PAUSE
//   stop         pulse: RUN/PAUSE -> IDLE, address back to 0
//   dir          (SNAKE_REVERSE_EN only) 0 = forward, 1 = reverse
//   seg_in0..3   active-low segment patterns from the digit ROMs
//   addr         frame address shared by the four ROMs
//   seg          active-low segments of the scanned digit
//   dp           decimal point, active-low, always off
//   com          active-low one-hot digit enables
//   frame_wrap   one-cycle pulse when the address wraps
//   busy         high while in RUN or PAUSE
// -----------------------------------------------------------------------------
module snake_ctrl #(
  parameter int unsigned DIV_TICK = 2500000,
  parameter int unsigned DIV_SCAN = 50000,
  parameter int unsigned FRAMES   = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  input  logic       stop,
`ifdef SNAKE_REVERSE_EN
  input  logic       dir,
`endif
  input  logic [6:0] seg_in0,
  input  logic [6:0] seg_in1,
  input  logic [6:0] seg_in2,
  input  logic [6:0] seg_in3,
  output logic [4:0] addr,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] com,
  output logic       frame_wrap,
  output logic       busy
);

  localparam int unsigned TICK_W = $clog2(DIV_TICK);
  localparam int unsigned SCAN_W = $clog2(DIV_SCAN);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DIV_TICK - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(DIV_SCAN - 1);
  localparam logic [4:0]        ADDR_LAST = 5'(FRAMES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  state_e              state_q;
  state_e              state_d;
  logic [TICK_W-1:0]   tick_cnt;
  logic [SCAN_W-1:0]   scan_cnt;
  logic [1:0]          idx;
  logic                reverse;
  logic [4:0]          addr_next;
  logic                addr_wrap;
  logic [6:0]          seg_sel;

`ifdef SNAKE_REVERSE_EN
  assign reverse = dir;
`else
  assign reverse = 1'b0;
`endif

  assign dp = 1'b1;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: all clocked state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. stop beats start beats pause.
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default before the case so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start)      state_d = ST_RUN;
      ST_RUN:   if (stop)       state_d = ST_IDLE;
                else if (pause) state_d = ST_PAUSE;
      ST_PAUSE: if (stop)       state_d = ST_IDLE;
                else if (pause) state_d = ST_RUN;
      default:                  state_d = ST_IDLE;
    endcase
  end

  // Address step with wrap in either direction.
  always_comb begin
    addr_next = addr;
    addr_wrap = 1'b0;
    if (reverse) begin
      if (addr == 5'd0) begin
        addr_next = ADDR_LAST;
        addr_wrap = 1'b1;
      end else begin
        addr_next = addr - 5'd1;
      end
    end else begin
      if (addr >= ADDR_LAST) begin
        addr_next = 5'd0;
        addr_wrap = 1'b1;
      end else begin
        addr_next = addr + 5'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Step counter, frame address, wrap pulse, busy flag.
  // Leaving for IDLE (stop) clears everything; the counter only advances while
  // the current state is RUN, so a PAUSE holds the partial count and the cycle
  // that samples start or resume is not counted.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt   <= '0;
      addr       <= 5'd0;
      frame_wrap <= 1'b0;
      busy       <= 1'b0;
    end else begin
      frame_wrap <= 1'b0;
      busy       <= (state_d != ST_IDLE);
      if (state_d == ST_IDLE) begin
        tick_cnt <= '0;
        addr     <= 5'd0;
      end else if (state_q == ST_RUN) begin
        if (tick_cnt == TICK_LAST) begin
          tick_cnt   <= '0;
          addr       <= addr_next;
          frame_wrap <= addr_wrap;
        end else begin
          tick_cnt <= tick_cnt + TICK_W'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Digit scan: free-running in all states.
  // ---------------------------------------------------------------------------
  always_comb begin
    seg_sel = 7'h7F;
    unique case (idx)
      2'd0: seg_sel = seg_in0;
      2'd1: seg_sel = seg_in1;
      2'd2: seg_sel = seg_in2;
      2'd3: seg_sel = seg_in3;
      default: seg_sel = 7'h7F;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      idx      <= 2'd0;
      com      <= 4'b1110;
      seg      <= 7'h7F;
    end else begin
      if (scan_cnt == SCAN_LAST) begin
        scan_cnt <= '0;
        idx      <= idx + 2'd1;
      end else begin
        scan_cnt <= scan_cnt + SCAN_W'(1);
      end
      // com and seg both follow idx by one register stage so they stay aligned.
      com <= ~(4'b0001 << idx);
      seg <= (state_q == ST_IDLE) ? 7'h7F : seg_sel;
    end
  end

endmodule

// File: tb/tb_snake_ctrl.sv
// -----------------------------------------------------------------------------
// tb_snake_ctrl
//
// Scoreboard bench for snake_ctrl with DIV_TICK=4, DIV_SCAN=2, FRAMES=20.
// Each scenario pushes timed expectations (absolute edge index, signal,
// value) into a queue before driving its stimulus; a negedge monitor pops
// every entry whose time has come and compares it with the DUT output.
// "Cycle n" of a scenario is the value seen after the n-th edge following the
// edge that samples start (that edge is cycle 0).
// -----------------------------------------------------------------------------
module tb_snake_ctrl;

  localparam int unsigned DIV_TICK = 4;
  localparam int unsigned DIV_SCAN = 2;
  localparam int unsigned FRAMES   = 20;

  typedef enum int {S_ADDR, S_SEG, S_COM, S_DP, S_WRAP, S_BUSY} sig_e;

  typedef struct {
    int         at;
    string      tag;
    sig_e       sel;
    logic [6:0] val;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       stop = 1'b0;
`ifdef SNAKE_REVERSE_EN
  logic       dir = 1'b0;
`endif
  logic [6:0] pat [4];
  logic [4:0] addr;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] com;
  logic       frame_wrap;
  logic       busy;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];

  initial begin
    pat[0] = 7'h7E;
    pat[1] = 7'h3F;
    pat[2] = 7'h77;
    pat[3] = 7'h7F;
  end

  snake_ctrl #(
    .DIV_TICK(DIV_TICK),
    .DIV_SCAN(DIV_SCAN),
    .FRAMES  (FRAMES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pause     (pause),
    .stop      (stop),
`ifdef SNAKE_REVERSE_EN
    .dir       (dir),
`endif
    .seg_in0   (pat[0]),
    .seg_in1   (pat[1]),
    .seg_in2   (pat[2]),
    .seg_in3   (pat[3]),
    .addr      (addr),
    .seg       (seg),
    .dp        (dp),
    .com       (com),
    .frame_wrap(frame_wrap),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Edge counter: after edge k, cyc == k.
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #50000;
    $display("FAIL timeout: run did not finish, cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [6:0] observe(input sig_e s);
    case (s)
      S_ADDR:  return {2'b00, addr};
      S_SEG:   return seg;
      S_COM:   return {3'b000, com};
      S_DP:    return {6'd0, dp};
      S_WRAP:  return {6'd0, frame_wrap};
      S_BUSY:  return {6'd0, busy};
      default: return 7'h00;
    endcase
  endfunction

  function automatic void expect_at(input int at, input string tag, input sig_e sel,
                                    input logic [6:0] val);
    exp_t e;
    e.at  = at;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb.push_back(e);
  endfunction

  // Monitor: compare due entries, flag entries whose time slipped past.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at == cyc) begin
        check(sb[i].tag, 32'(observe(sb[i].sel)), 32'(sb[i].val));
        sb.delete(i);
      end else if (sb[i].at < cyc) begin
        check({sb[i].tag, " missed"}, 32'(cyc), 32'(sb[i].at));
        sb.delete(i);
      end
    end
  end

  // All tasks below are entered and left on a negedge.
  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // One-cycle pulse sampled at scenario cycle n (absolute edge b+n).
  task automatic drive(input int b, input int n, input logic s_start,
                       input logic s_pause, input logic s_stop);
    wait_until(b + n - 1);
    start = s_start;
    pause = s_pause;
    stop  = s_stop;
    @(negedge clk);
    start = 1'b0;
    pause = 1'b0;
    stop  = 1'b0;
  endtask

  // Two-cycle reset; r returns the edge index of the last reset edge.
  task automatic do_reset(input string name, output int r);
    r = cyc + 2;
    expect_at(r, {name, ".addr"}, S_ADDR, 7'd0);
    expect_at(r, {name, ".busy"}, S_BUSY, 7'd0);
    expect_at(r, {name, ".wrap"}, S_WRAP, 7'd0);
    expect_at(r, {name, ".com"},  S_COM,  7'h0E);
    expect_at(r, {name, ".seg"},  S_SEG,  7'h7F);
    expect_at(r, {name, ".dp"},   S_DP,   7'd1);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int r;
    int b;
    int b2;
    logic [3:0] c_exp;
    int d;

    @(negedge clk);

    // ---- Reset, then a full animation lap with wrap, then stop ----
    do_reset("rst0", r);
    b = r + 1;
    expect_at(b + 1, "s1.busy@1", S_BUSY, 7'd1);
    for (int n = 1; n <= 84; n++) begin
      expect_at(b + n, $sformatf("s1.addr@%0d", n), S_ADDR, 7'((n / 4) % 20));
      expect_at(b + n, $sformatf("s1.wrap@%0d", n), S_WRAP, (n == 80) ? 7'd1 : 7'd0);
    end
    expect_at(b + 85, "s1.stop.addr", S_ADDR, 7'd0);
    expect_at(b + 85, "s1.stop.busy", S_BUSY, 7'd0);
    expect_at(b + 85, "s1.stop.wrap", S_WRAP, 7'd0);
    expect_at(b + 87, "s1.stop.seg",  S_SEG,  7'h7F);
    drive(b, 0, 1'b1, 1'b0, 1'b0);
    drive(b, 85, 1'b0, 1'b0, 1'b1);
    wait_until(b + 88);

    // ---- Pause holds the partial count; resume continues it ----
    do_reset("rst1", r);
    b = r + 1;
    for (int n = 1; n <= 28; n++) begin
      expect_at(b + n, $sformatf("s2.addr@%0d", n), S_ADDR,
                (n < 4) ? 7'd0 : (n < 22) ? 7'd1 : 7'd2);
    end
    expect_at(b + 10, "s2.busy.paused", S_BUSY, 7'd1);
    expect_at(b + 26, "s2.busy.paused2", S_BUSY, 7'd1);
    drive(b, 0, 1'b1, 1'b0, 1'b0);
    drive(b, 6, 1'b0, 1'b1, 1'b0);
    drive(b, 20, 1'b0, 1'b1, 1'b0);
    drive(b, 24, 1'b0, 1'b1, 1'b0);
    wait_until(b + 28);
    // Reset while paused.
    do_reset("rst2.pause", r);

    // ---- stop+pause together, pause in IDLE, restart, start in RUN ----
    b = r + 1;
    expect_at(b + 8,  "s3.addr@8",     S_ADDR, 7'd2);
    expect_at(b + 9,  "s3.stop.addr",  S_ADDR, 7'd0);
    expect_at(b + 9,  "s3.stop.busy",  S_BUSY, 7'd0);
    expect_at(b + 9,  "s3.stop.wrap",  S_WRAP, 7'd0);
    expect_at(b + 11, "s3.stop.seg",   S_SEG,  7'h7F);
    expect_at(b + 13, "s3.idle.pause", S_BUSY, 7'd0);
    expect_at(b + 15, "s3.idle.addr",  S_ADDR, 7'd0);
    b2 = b + 16;
    expect_at(b2 + 1, "s3.restart.busy", S_BUSY, 7'd1);
    expect_at(b2 + 3, "s3.restart.a3",   S_ADDR, 7'd0);
    expect_at(b2 + 4, "s3.restart.a4",   S_ADDR, 7'd1);
    expect_at(b2 + 8, "s3.start_in_run", S_ADDR, 7'd2);
    expect_at(b2 + 9, "s3.run.busy",     S_BUSY, 7'd1);
    drive(b, 0, 1'b1, 1'b0, 1'b0);
    drive(b, 9, 1'b0, 1'b1, 1'b1);
    drive(b, 12, 1'b0, 1'b1, 1'b0);
    drive(b2, 0, 1'b1, 1'b0, 1'b0);
    drive(b2, 6, 1'b1, 1'b0, 1'b0);
    wait_until(b2 + 10);
    // Reset while running.
    do_reset("rst3.run", r);

    // ---- Digit scan: com rotates every 2 cycles, seg follows digit ----
    b = r + 1;
    for (int k = 2; k <= 13; k++) begin
      d = ((k - 1) / 2) % 4;
      c_exp = ~(4'b0001 << d);
      expect_at(r + k, $sformatf("s4.com@%0d", k), S_COM, {3'b000, c_exp});
      expect_at(r + k, $sformatf("s4.seg@%0d", k), S_SEG, pat[d]);
    end
    drive(b, 0, 1'b1, 1'b0, 1'b0);
    wait_until(r + 14);

`ifdef SNAKE_REVERSE_EN
    // ---- Reverse: 0 -> 19 with wrap pulse at the first step, then reset ----
    do_reset("rst4", r);
    dir = 1'b1;
    b = r + 1;
    expect_at(b + 3, "s5.addr@3", S_ADDR, 7'd0);
    expect_at(b + 3, "s5.wrap@3", S_WRAP, 7'd0);
    expect_at(b + 4, "s5.addr@4", S_ADDR, 7'd19);
    expect_at(b + 4, "s5.wrap@4", S_WRAP, 7'd1);
    expect_at(b + 5, "s5.wrap@5", S_WRAP, 7'd0);
    drive(b, 0, 1'b1, 1'b0, 1'b0);
    wait_until(b + 5);
    do_reset("rst5.rev", r);
    dir = 1'b0;
`endif

    wait_until(cyc + 3);
    check("sb_leftover", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
